// File: rtl/d_memory_port_arbiter.sv
// d_memory_port_arbiter
//   Shares one data-memory port between NUM_REQ requesters (load-store unit,
//   store drain, debug). Only one transaction is outstanding at a time.
//   Requesters are served round-robin, and every transaction has an ack timeout.
//
// State | meaning
//   IDLE     | waiting for a request; grant is combinational here only
//   ISSUE    | memory_req_valid held with latched fields until memory_ready
//   WAIT_ACK | waiting for memory_ack; timeout counter running
//   RESP     | one-cycle completion pulse to the owning requester
//
// Ports
//   clk, reset                   clock; asynchronous active-low reset
//   req_valid/op/addr/data/tag   per-requester access (op: 0 = read, 1 = write)
//   req_grant                    one-hot accept, asserted in IDLE only
//   resp_valid/data/tag/timeout  one-cycle completion toward the owner
//   memory_ready/req_*           request handshake toward memory
//   memory_ack/data_return       completion from memory
module d_memory_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5,
  parameter int TIMEOUT    = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0]                    req_op,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ-1:0][TAG_WIDTH-1:0]     req_tag,
  output logic [NUM_REQ-1:0]                    req_grant,
  output logic [NUM_REQ-1:0]                    resp_valid,
  output logic [DATA_WIDTH-1:0]                 resp_data,
  output logic [TAG_WIDTH-1:0]                  resp_tag,
  output logic                                  resp_timeout,
  input  logic                                  memory_ready,
  output logic                                  memory_req_valid,
  output logic                                  memory_req_op,
  output logic [ADDR_WIDTH-1:0]                 memory_req_address,
  output logic [DATA_WIDTH-1:0]                 memory_req_data,
  input  logic                                  memory_ack,
  input  logic [DATA_WIDTH-1:0]                 memory_data_return
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic MEM_READ = 1'b0;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ISSUE    = 2'd1;
  localparam logic [1:0] S_WAIT_ACK = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  mreq_vld_q, mreq_vld_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  tout_q, tout_d;

  logic                  any_valid;
  logic [IDX_W-1:0]      sel;
  logic [IDX_W-1:0]      cand;
  int unsigned           arb_j;

  // Scan from the round-robin pointer, wrapping, and pick the first valid.
  always_comb begin
    any_valid = 1'b0;
    sel       = '0;
    cand      = '0;
    arb_j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_j = int'(rr_q) + k;
      if (arb_j >= NUM_REQ) arb_j = arb_j - NUM_REQ;
      cand = IDX_W'(arb_j);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        sel       = cand;
      end
    end
  end

  // The reset term keeps the grant low while reset is held, even when
  // requesters keep their valid lines up through reset.
  assign req_grant = (state_q == S_IDLE && reset && any_valid)
                     ? (NUM_REQ'(1) << sel) : '0;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    idx_d      = idx_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tag_d      = tag_q;
    mreq_vld_d = mreq_vld_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    tout_d     = tout_q;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          idx_d      = sel;
          op_d       = req_op[sel];
          addr_d     = req_addr[sel];
          wdata_d    = req_data[sel];
          tag_d      = req_tag[sel];
          mreq_vld_d = 1'b1;
          rdata_d    = '0;
          tout_d     = 1'b0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (memory_ready) begin
          mreq_vld_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        // An ack on the last permitted cycle still wins over the timeout.
        if (memory_ack) begin
          rdata_d = (op_q == MEM_READ) ? memory_data_return : '0;
          tout_d  = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          tout_d  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rr_d    = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      idx_q      <= '0;
      op_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tag_q      <= '0;
      mreq_vld_q <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      idx_q      <= idx_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tag_q      <= tag_d;
      mreq_vld_q <= mreq_vld_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      tout_q     <= tout_d;
    end
  end

  assign memory_req_valid   = mreq_vld_q;
  assign memory_req_op      = op_q;
  assign memory_req_address = addr_q;
  assign memory_req_data    = wdata_q;

  assign resp_valid   = (state_q == S_RESP) ? (NUM_REQ'(1) << idx_q) : '0;
  assign resp_data    = (state_q == S_RESP) ? rdata_q : '0;
  assign resp_tag     = (state_q == S_RESP) ? tag_q : '0;
  assign resp_timeout = (state_q == S_RESP) ? tout_q : 1'b0;

endmodule
